calc_controller: RTL

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calc_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/calc_controller.sv
// Two-operand BCD calculator controller: power toggle, add/sub/mult, double-dabble.
// Optional CALC_LEADING_ZERO_BLANK_EN blanks leading zeros of soma/mult results.
module calc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] numero0,
  input  logic [6:0] numero1,
  input  logic       btn_on,
  input  logic       btn_soma,
  input  logic       btn_sub,
  input  logic       btn_mult,
  output logic [2:0] ea,
  output logic [3:0] dec0,
  output logic [3:0] uni0,
  output logic [3:0] dec1,
  output logic [3:0] uni1,
  output logic [3:0] milR,
  output logic [3:0] cenR,
  output logic [3:0] decR,
  output logic [3:0] uniR,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {
    S_OFF, S_IDLE, S_CALC, S_CONV, S_SHOW
  } state_t;

  localparam logic [3:0] BLANK = 4'd10;
  localparam logic [3:0] MINUS = 4'd11;

  state_t state, nxt;
  logic on_q, soma_q, sub_q, mult_q;
  logic on_r, soma_r, sub_r, mult_r, op_go;
  logic [2:0] op, op_sel;
  logic [6:0] a, b, a_cl, b_cl;
  logic [13:0] res, res_nxt;
  logic neg, show_go;
  logic [3:0] cnt;
  logic [29:0] sr, sr_adj, dd_nxt;
  logic [3:0] m, c, d, u;
  logic [3:0] pm, pc, pd, pu;

  function automatic logic [3:0] tens(input logic [6:0] v);
    logic [6:0] q;
    q = v / 7'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] ones(input logic [6:0] v);
    logic [6:0] q;
    q = v % 7'd10;
    return q[3:0];
  endfunction

  assign on_r   = btn_on & ~on_q;
  assign soma_r = btn_soma & ~soma_q;
  assign sub_r  = btn_sub & ~sub_q;
  assign mult_r = btn_mult & ~mult_q;
  assign op_go  = soma_r | sub_r | mult_r;

  assign a_cl = (numero0 > 7'd99) ? 7'd99 : numero0;
  assign b_cl = (numero1 > 7'd99) ? 7'd99 : numero1;

  assign busy    = (state == S_CALC) || (state == S_CONV);
  assign show_go = (state == S_CONV) && (nxt == S_SHOW);

  always_comb begin
    op_sel = 3'd4;
    if (soma_r)     op_sel = 3'd2;
    else if (sub_r) op_sel = 3'd3;
  end

  always_comb begin
    ea = op;
    if (state == S_OFF)       ea = 3'd0;
    else if (state == S_IDLE) ea = 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_OFF;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_OFF:
        if (on_r) nxt = S_IDLE;
      S_IDLE, S_SHOW:
        if (on_r)       nxt = S_OFF;
        else if (op_go) nxt = S_CALC;
      S_CALC:
        if (on_r) nxt = S_OFF;
        else if (op != 3'd4 || cnt == 4'd6) nxt = S_CONV;
      S_CONV:
        if (on_r) nxt = S_OFF;
        else if (cnt == 4'd13) nxt = S_SHOW;
      default: nxt = S_OFF;
    endcase
  end

  // mult adds a<<i for each set bit i of b, one bit per cycle
  always_comb begin
    res_nxt = res;
    if (op == 3'd2)
      res_nxt = {7'd0, a} + {7'd0, b};
    else if (op == 3'd3)
      res_nxt = (a < b) ? {7'd0, b - a} : {7'd0, a - b};
    else if (b[cnt[2:0]])
      res_nxt = res + ({7'd0, a} << cnt[2:0]);
  end

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 4; i++)
      if (sr[14+4*i +: 4] >= 4'd5)
        sr_adj[14+4*i +: 4] = sr[14+4*i +: 4] + 4'd3;
    dd_nxt = {sr_adj[28:0], 1'b0};
  end

  assign m = dd_nxt[29:26];
  assign c = dd_nxt[25:22];
  assign d = dd_nxt[21:18];
  assign u = dd_nxt[17:14];

  always_comb begin
    pm = m;
    pc = c;
    pd = d;
    pu = u;
    if (op == 3'd2) begin
      pm = BLANK;
`ifdef CALC_LEADING_ZERO_BLANK_EN
      if (c == 4'd0) begin
        pc = BLANK;
        if (d == 4'd0) pd = BLANK;
      end
`endif
    end else if (op == 3'd3) begin
      pm = BLANK;
      pc = neg ? MINUS : BLANK;
    end else begin
`ifdef CALC_LEADING_ZERO_BLANK_EN
      if (m == 4'd0) pm = BLANK;
      if (m == 4'd0 && c == 4'd0) pc = BLANK;
      if (m == 4'd0 && c == 4'd0 && d == 4'd0) pd = BLANK;
`endif
    end
  end

  // button levels load during reset too, so a held button yields no rise
  always_ff @(posedge clk) begin
    on_q   <= btn_on;
    soma_q <= btn_soma;
    sub_q  <= btn_sub;
    mult_q <= btn_mult;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op   <= 3'd0;
      a    <= 7'd0;
      b    <= 7'd0;
      res  <= 14'd0;
      neg  <= 1'b0;
      cnt  <= 4'd0;
      sr   <= 30'd0;
      done <= 1'b0;
      dec0 <= BLANK;
      uni0 <= BLANK;
      dec1 <= BLANK;
      uni1 <= BLANK;
      milR <= BLANK;
      cenR <= BLANK;
      decR <= BLANK;
      uniR <= BLANK;
    end else begin
      done <= show_go;
      if (state == S_OFF || nxt == S_OFF) begin
        dec0 <= BLANK;
        uni0 <= BLANK;
        dec1 <= BLANK;
        uni1 <= BLANK;
      end else begin
        dec0 <= tens(a_cl);
        uni0 <= ones(a_cl);
        dec1 <= tens(b_cl);
        uni1 <= ones(b_cl);
      end
      if (nxt == S_OFF) begin
        milR <= BLANK;
        cenR <= BLANK;
        decR <= BLANK;
        uniR <= BLANK;
      end else if (show_go) begin
        milR <= pm;
        cenR <= pc;
        decR <= pd;
        uniR <= pu;
      end
      unique case (state)
        S_IDLE, S_SHOW:
          if (nxt == S_CALC) begin
            op  <= op_sel;
            a   <= a_cl;
            b   <= b_cl;
            res <= 14'd0;
            neg <= 1'b0;
            cnt <= 4'd0;
          end
        S_CALC: begin
          res <= res_nxt;
          cnt <= cnt + 4'd1;
          if (op == 3'd3) neg <= (a < b);
          if (nxt == S_CONV) begin
            sr  <= {16'd0, res_nxt};
            cnt <= 4'd0;
          end
        end
        S_CONV: begin
          sr  <= dd_nxt;
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
